chunk_fetch_sequencer: RTL and testbench
========================================

Name: chunk_fetch_sequencer

Overview:
- Sits directly downstream of the chunk address looper in the TileAccumUnit read pipeline and consumes its cmd stream (type, islast, addr, addrofs, len).
- Type-0 commands become DRAM read requests; the returned vector is held in a one-entry line buffer.
- Every command that shares the same DRAM address (a group ending with islast=1) slices that buffer into cache-write transactions.
- Type-1 commands produce zero (padding) writes; type-2 commands are consumed without side effects.

Parameters:
- GBW, 32, global DRAM address width
- VSIZE, 32, lanes per DRAM vector / cache write
- CSIZE, 1024, cache entries; C_BW = clog2(CSIZE)
- DW, 16, bits per lane
- V_BW1, clog2(VSIZE+1) (derived), width of len

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- cmd_rdy  in  1  command valid
- cmd_ack  out  1  command retired (combinational)
- i_cmd_type  in  2  0=DRAM fetch, 1=pad zero, 2=skip
- i_cmd_islast  in  1  last command using this DRAM address
- i_cmd_addr  in  GBW  DRAM vector address
- i_cmd_addrofs  in  C_BW  cache write offset
- i_cmd_len  in  V_BW1  valid lanes, 0..VSIZE
- dramra_rdy  out  1  DRAM read-address request valid
- dramra_ack  in  1  DRAM accepted address
- o_dramra_addr  out  GBW  request address (= i_cmd_addr)
- dramrd_rdy  in  1  DRAM read data valid
- dramrd_ack  out  1  read data consumed
- i_dramrd  in  VSIZE*DW  read data, lane 0 in LSBs
- sramwr_rdy  out  1  cache write valid
- sramwr_ack  in  1  cache write accepted
- o_sramwr_addrofs  out  C_BW  = i_cmd_addrofs
- o_sramwr_mask  out  VSIZE  bit i = (i < len)
- o_sramwr_data  out  VSIZE*DW  buffer (type 0) or zero (type 1)

Behaviour:
- Handshake: rdy/ack. ack only while rdy is high. A source holds rdy and data stable until ack. The upstream cmd source holds i_cmd_* until cmd_ack, so the block reads i_cmd_* directly and does not register the command.
- State: FSM {IDLE, REQ, RESP, WRITE}; line buffer buf_data[VSIZE*DW], buf_addr[GBW], buf_valid.
- IDLE, cmd_rdy=0: stay.
- IDLE, cmd_rdy=1, type 2, or len==0 for any type: cmd_ack=1 in the same cycle; stay IDLE. No DRAM access, no write, buffer untouched.
- IDLE, cmd_rdy=1, type 1: go to WRITE.
- IDLE, cmd_rdy=1, type 0, hit (buf_valid && buf_addr==i_cmd_addr): go to WRITE.
- IDLE, cmd_rdy=1, type 0, miss: go to REQ.
- Type 3 is treated as type 2.
- REQ: dramra_rdy=1. On dramra_ack go to RESP.
- RESP: dramrd_ack=dramrd_rdy. On ack, latch buf_data<=i_dramrd, buf_addr<=i_cmd_addr, buf_valid<=1, then go to WRITE. A miss overwrites any prior buffer contents.
- WRITE: sramwr_rdy=1. Data = buf_data for type 0, zero for type 1. Mask from len.
- WRITE, on sramwr_ack: cmd_ack=1 in the same cycle; go to IDLE. If type 0 and islast=1, clear buf_valid on the following edge.
- islast on type 1 or 2 has no effect on the buffer.
- dramra_rdy, dramrd_ack and sramwr_rdy are 0 outside their states. Only one DRAM request is outstanding at any time.
- Latency with zero-wait neighbours:
  - miss: 4 cycles from cmd_rdy to cmd_ack
  - hit or type 1: 2 cycles
  - type 2: 1 cycle (ack in the cycle of cmd_rdy)
- len is unsigned; len==VSIZE gives an all-ones mask; len>VSIZE is illegal and its mask is undefined.
- addrofs is passed through unchanged; cache wrap-around is the consumer's responsibility.
- Reset: state=IDLE, buf_valid=0, buf_data=0, buf_addr=0. cmd_ack, dramra_rdy, dramrd_ack and sramwr_rdy are all 0 in the reset cycle and the cycle after.
- Reset mid-operation abandons the in-flight command without acking it. The DRAM side must be reset together with this block; a stale response is never acked because the block is no longer in RESP.
- Simultaneous events: in WRITE, a new cmd_rdy is not examined until IDLE. dramrd_rdy arriving during REQ is ignored until RESP.

Test Plan:
- Reset, then type 0, addr=0x100, ofs=5, len=32, islast=1, DRAM data = lane index: one dramra (addr 0x100), mask=0xFFFFFFFF, data lanes 0..31, cmd_ack at cycle 4, buf_valid=0 afterwards.
- Group: three type-0 cmds at addr=0x200, len=8,8,4, islast=0,0,1: exactly one DRAM request; three writes with masks 0xFF, 0xFF, 0xF from the same buffer; 2-cycle latency on the second and third.
- Type 1, len=3, ofs=7: no DRAM activity, data=0, mask=0x7, ofs=7.
- Type 2, and type 0 with len=0: cmd_ack in the same cycle; no dramra_rdy, no sramwr_rdy.
- Backpressure: dramra_ack delayed 5 cycles, dramrd_rdy delayed 10 cycles, sramwr_ack delayed 3 cycles: rdy held and outputs stable throughout; one cmd_ack only.
- Assert i_rst while in RESP, then drive a stale dramrd_rdy: dramrd_ack stays 0, no cmd_ack. The next type-0 cmd to the same address issues a fresh DRAM request (buffer invalid).

Source files
------------

// File: rtl/chunk_fetch_sequencer.sv
// Turns chunk-looper commands into DRAM line fetches and masked cache writes,
// reusing a one-entry line buffer across commands that share a DRAM address.
module chunk_fetch_sequencer #(
   parameter  int GBW   = 32,
   parameter  int VSIZE = 32,
   parameter  int CSIZE = 1024,
   parameter  int DW    = 16,
   localparam int C_BW  = $clog2(CSIZE),
   localparam int V_BW1 = $clog2(VSIZE + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  cmd_rdy,
   output logic                  cmd_ack,
   input  logic [1:0]            i_cmd_type,
   input  logic                  i_cmd_islast,
   input  logic [GBW-1:0]        i_cmd_addr,
   input  logic [C_BW-1:0]       i_cmd_addrofs,
   input  logic [V_BW1-1:0]      i_cmd_len,
   output logic                  dramra_rdy,
   input  logic                  dramra_ack,
   output logic [GBW-1:0]        o_dramra_addr,
   input  logic                  dramrd_rdy,
   output logic                  dramrd_ack,
   input  logic [VSIZE*DW-1:0]   i_dramrd,
   output logic                  sramwr_rdy,
   input  logic                  sramwr_ack,
   output logic [C_BW-1:0]       o_sramwr_addrofs,
   output logic [VSIZE-1:0]      o_sramwr_mask,
   output logic [VSIZE*DW-1:0]   o_sramwr_data
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_WRITE} state_t;

   state_t                state_q, state_d;
   logic [VSIZE*DW-1:0]   buf_data_q, buf_data_d;
   logic [GBW-1:0]        buf_addr_q, buf_addr_d;
   logic                  buf_valid_q, buf_valid_d;
   logic                  rst_q;
   logic                  hold;
   logic                  is_skip;
   logic                  hit;

   function automatic logic [VSIZE-1:0] len_mask(input logic [V_BW1-1:0] len);
      logic [VSIZE-1:0] m;
      for (int i = 0; i < VSIZE; i++) begin
         m[i] = (i < int'(len));
      end
      return m;
   endfunction

   // Handshake outputs stay quiet during reset and the cycle after it.
   assign hold    = i_rst | rst_q;
   assign is_skip = i_cmd_type[1] | (i_cmd_len == '0);
   assign hit     = buf_valid_q & (buf_addr_q == i_cmd_addr);

   always_comb begin
      state_d     = state_q;
      buf_data_d  = buf_data_q;
      buf_addr_d  = buf_addr_q;
      buf_valid_d = buf_valid_q;
      cmd_ack     = 1'b0;
      dramra_rdy  = 1'b0;
      dramrd_ack  = 1'b0;
      sramwr_rdy  = 1'b0;
      if (!hold) begin
         case (state_q)
            S_IDLE: begin
               if (cmd_rdy) begin
                  if (is_skip) begin
                     cmd_ack = 1'b1;
                  end else if (i_cmd_type[0] || hit) begin
                     state_d = S_WRITE;
                  end else begin
                     state_d = S_REQ;
                  end
               end
            end
            S_REQ: begin
               dramra_rdy = 1'b1;
               if (dramra_ack) state_d = S_RESP;
            end
            S_RESP: begin
               dramrd_ack = dramrd_rdy;
               if (dramrd_rdy) begin
                  buf_data_d  = i_dramrd;
                  buf_addr_d  = i_cmd_addr;
                  buf_valid_d = 1'b1;
                  state_d     = S_WRITE;
               end
            end
            S_WRITE: begin
               sramwr_rdy = 1'b1;
               if (sramwr_ack) begin
                  cmd_ack = 1'b1;
                  state_d = S_IDLE;
                  // Last user of this DRAM line releases the buffer.
                  if (i_cmd_type == 2'd0 && i_cmd_islast) buf_valid_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign o_dramra_addr    = i_cmd_addr;
   assign o_sramwr_addrofs = i_cmd_addrofs;
   assign o_sramwr_mask    = len_mask(i_cmd_len);
   assign o_sramwr_data    = i_cmd_type[0] ? '0 : buf_data_q;

   always_ff @(posedge i_clk) begin
      rst_q <= i_rst;
      if (i_rst) begin
         state_q     <= S_IDLE;
         buf_data_q  <= '0;
         buf_addr_q  <= '0;
         buf_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_data_q  <= buf_data_d;
         buf_addr_q  <= buf_addr_d;
         buf_valid_q <= buf_valid_d;
      end
   end

endmodule

// File: tb/tb_chunk_fetch_sequencer.sv
// Bench for chunk_fetch_sequencer: directed scenarios plus randomized commands
// checked against a line-buffer reference model.
module tb_chunk_fetch_sequencer;

   localparam int GBW   = 32;
   localparam int VSIZE = 32;
   localparam int CSIZE = 1024;
   localparam int DW    = 16;
   localparam int C_BW  = $clog2(CSIZE);
   localparam int V_BW1 = $clog2(VSIZE + 1);
   localparam int VW    = VSIZE * DW;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              cmd_rdy;
   logic              cmd_ack;
   logic [1:0]        i_cmd_type;
   logic              i_cmd_islast;
   logic [GBW-1:0]    i_cmd_addr;
   logic [C_BW-1:0]   i_cmd_addrofs;
   logic [V_BW1-1:0]  i_cmd_len;
   logic              dramra_rdy;
   logic              dramra_ack;
   logic [GBW-1:0]    o_dramra_addr;
   logic              dramrd_rdy;
   logic              dramrd_ack;
   logic [VW-1:0]     i_dramrd;
   logic              sramwr_rdy;
   logic              sramwr_ack;
   logic [C_BW-1:0]   o_sramwr_addrofs;
   logic [VSIZE-1:0]  o_sramwr_mask;
   logic [VW-1:0]     o_sramwr_data;

   int checks   = 0;
   int failures = 0;

   // Reference model: the single cached DRAM line.
   logic              m_valid;
   logic [GBW-1:0]    m_addr;
   logic [VW-1:0]     m_data;

   chunk_fetch_sequencer #(.GBW(GBW), .VSIZE(VSIZE), .CSIZE(CSIZE), .DW(DW)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .cmd_rdy(cmd_rdy), .cmd_ack(cmd_ack),
      .i_cmd_type(i_cmd_type), .i_cmd_islast(i_cmd_islast), .i_cmd_addr(i_cmd_addr),
      .i_cmd_addrofs(i_cmd_addrofs), .i_cmd_len(i_cmd_len),
      .dramra_rdy(dramra_rdy), .dramra_ack(dramra_ack), .o_dramra_addr(o_dramra_addr),
      .dramrd_rdy(dramrd_rdy), .dramrd_ack(dramrd_ack), .i_dramrd(i_dramrd),
      .sramwr_rdy(sramwr_rdy), .sramwr_ack(sramwr_ack),
      .o_sramwr_addrofs(o_sramwr_addrofs), .o_sramwr_mask(o_sramwr_mask),
      .o_sramwr_data(o_sramwr_data)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] rand_line();
      logic [VW-1:0] v;
      for (int i = 0; i < VSIZE; i++) v[i*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   function automatic logic [VW-1:0] lane_index_line();
      logic [VW-1:0] v;
      for (int i = 0; i < VSIZE; i++) v[i*DW +: DW] = DW'(i);
      return v;
   endfunction

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_cmd_ack"}, cmd_ack, 0);
      chk({tag, "_dramra_rdy"}, dramra_rdy, 0);
      chk({tag, "_dramrd_ack"}, dramrd_ack, 0);
      chk({tag, "_sramwr_rdy"}, sramwr_rdy, 0);
   endtask

   task automatic do_reset();
      i_rst = 1'b1; cmd_rdy = 1'b0; dramra_ack = 1'b0; dramrd_rdy = 1'b0; sramwr_ack = 1'b0;
      #2;
      chk_idle_outputs("rst_cycle");
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      #1;
      chk_idle_outputs("rst_after");
      @(posedge i_clk); #1;
      m_valid = 1'b0;
      m_addr  = '0;
      m_data  = '0;
   endtask

   // Presents one command and plays DRAM and cache with the given wait states.
   task automatic run_cmd(input logic [1:0] typ, input logic last, input logic [GBW-1:0] addr,
                          input logic [C_BW-1:0] ofs, input logic [V_BW1-1:0] len,
                          input logic [VW-1:0] rdata, input int ra_w, input int rd_w, input int wr_w);
      bit miss, wr, done, ra_done, rd_done;
      int cyc, ra_cnt, rd_cnt, wr_cnt, nreq, nwr, exp_lat;
      logic [VW-1:0]    exp_data;
      logic [VSIZE-1:0] exp_mask;
      logic [63:0]      ones;
      wr       = (typ <= 2'd1) && (len != '0);
      miss     = wr && (typ == 2'd0) && !(m_valid && m_addr == addr);
      exp_data = (typ == 2'd0) ? (miss ? rdata : m_data) : '0;
      ones     = (64'd1 << len) - 64'd1;
      exp_mask = ones[VSIZE-1:0];
      exp_lat  = !wr ? 1 : (miss ? 4 + ra_w + rd_w + wr_w : 2 + wr_w);
      done = 0; ra_done = 0; rd_done = 0;
      cyc = 0; ra_cnt = 0; rd_cnt = 0; wr_cnt = 0; nreq = 0; nwr = 0;
      i_cmd_type = typ; i_cmd_islast = last; i_cmd_addr = addr;
      i_cmd_addrofs = ofs; i_cmd_len = len; i_dramrd = rdata;
      cmd_rdy = 1'b1;
      while (!done && cyc < 200) begin
         cyc++;
         dramrd_rdy = ra_done && !rd_done && (rd_cnt > rd_w);
         #1;
         dramra_ack = dramra_rdy && (ra_cnt >= ra_w);
         sramwr_ack = sramwr_rdy && (wr_cnt >= wr_w);
         #1;
         if (dramra_rdy) begin
            chk("dramra_addr", o_dramra_addr, addr);
            ra_cnt++;
            if (dramra_ack) begin nreq++; ra_done = 1; end
         end
         chk("dramrd_ack", dramrd_ack, dramrd_rdy);
         if (dramrd_rdy && dramrd_ack) rd_done = 1;
         if (sramwr_rdy) begin
            chk("wr_ofs", o_sramwr_addrofs, ofs);
            chk("wr_mask", o_sramwr_mask, exp_mask);
            chk("wr_data", o_sramwr_data, exp_data);
            wr_cnt++;
            if (sramwr_ack) nwr++;
         end
         if (cmd_ack) done = 1;
         @(posedge i_clk); #1;
         if (ra_done) rd_cnt++;
         dramra_ack = 1'b0; sramwr_ack = 1'b0; dramrd_rdy = 1'b0;
      end
      cmd_rdy = 1'b0;
      chk("cmd_ack_seen", done, 1);
      chk("latency", cyc, exp_lat);
      chk("dram_reqs", nreq, miss);
      chk("sram_writes", nwr, wr);
      if (miss) begin m_valid = 1'b1; m_addr = addr; m_data = rdata; end
      if (wr && typ == 2'd0 && last) m_valid = 1'b0;
   endtask

   initial begin
      logic [GBW-1:0] a;
      int r;
      i_rst = 1'b1; cmd_rdy = 1'b0; i_cmd_type = '0; i_cmd_islast = 1'b0; i_cmd_addr = '0;
      i_cmd_addrofs = '0; i_cmd_len = '0; dramra_ack = 1'b0; dramrd_rdy = 1'b0;
      sramwr_ack = 1'b0; i_dramrd = '0;
      do_reset();

      // Single miss, full line, released by islast; the re-read must miss again.
      run_cmd(2'd0, 1'b1, 32'h100, 10'd5, 6'd32, lane_index_line(), 0, 0, 0);
      run_cmd(2'd0, 1'b1, 32'h100, 10'd6, 6'd32, rand_line(), 0, 0, 0);

      // Three commands sharing one DRAM line.
      run_cmd(2'd0, 1'b0, 32'h200, 10'd0,  6'd8, rand_line(), 0, 0, 0);
      run_cmd(2'd0, 1'b0, 32'h200, 10'd8,  6'd8, rand_line(), 0, 0, 0);
      run_cmd(2'd0, 1'b1, 32'h200, 10'd16, 6'd4, rand_line(), 0, 0, 0);

      // Padding, skip, zero-length, and type 3.
      run_cmd(2'd1, 1'b1, 32'h0,   10'd7,  6'd3, rand_line(), 0, 0, 0);
      run_cmd(2'd2, 1'b1, 32'h0,   10'd9,  6'd5, rand_line(), 0, 0, 0);
      run_cmd(2'd0, 1'b1, 32'h300, 10'd1,  6'd0, rand_line(), 0, 0, 0);
      run_cmd(2'd3, 1'b0, 32'h300, 10'd2,  6'd9, rand_line(), 0, 0, 0);
      run_cmd(2'd1, 1'b0, 32'h0,   10'd1023, 6'd1, rand_line(), 0, 0, 0);

      // Backpressure on every interface.
      run_cmd(2'd0, 1'b1, 32'hABC, 10'd33, 6'd17, rand_line(), 5, 10, 3);

      // Reset while waiting for read data.
      run_cmd(2'd0, 1'b0, 32'h400, 10'd2, 6'd16, rand_line(), 0, 0, 0);
      i_cmd_type = 2'd0; i_cmd_islast = 1'b1; i_cmd_addr = 32'h500;
      i_cmd_addrofs = 10'd3; i_cmd_len = 6'd8; cmd_rdy = 1'b1;
      @(posedge i_clk); #1;
      dramra_ack = 1'b1;
      #1;
      chk("rst_test_req", dramra_rdy, 1);
      @(posedge i_clk); #1;
      dramra_ack = 1'b0;
      i_rst = 1'b1; dramrd_rdy = 1'b1; i_dramrd = rand_line();
      #1;
      chk("rst_resp_dramrd_ack", dramrd_ack, 0);
      chk("rst_resp_cmd_ack", cmd_ack, 0);
      @(posedge i_clk); #1;
      i_rst = 1'b0; cmd_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stale_dramrd_ack", dramrd_ack, 0);
         chk("stale_cmd_ack", cmd_ack, 0);
         chk("stale_sramwr_rdy", sramwr_rdy, 0);
         @(posedge i_clk); #1;
      end
      dramrd_rdy = 1'b0;
      m_valid = 1'b0;
      @(posedge i_clk); #1;
      run_cmd(2'd0, 1'b1, 32'h400, 10'd4, 6'd16, rand_line(), 0, 0, 0);
      run_cmd(2'd0, 1'b1, 32'h500, 10'd3, 6'd8,  rand_line(), 0, 1, 0);

      // Randomized commands over a small address set so hits occur.
      for (int n = 0; n < 60; n++) begin
         a = 32'h600 + GBW'($urandom_range(0, 2));
         r = $urandom_range(0, 7);
         run_cmd((r <= 4) ? 2'd0 : 2'(r - 4), 1'($urandom_range(0, 1)), a,
                 C_BW'($urandom), V_BW1'($urandom_range(0, VSIZE)), rand_line(),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
